// File: rtl/ceas_alarma.sv
// ceas_alarma: 24 h hh:mm:ss clock with one stored alarm and a ring/stop FSM
// Ports: clock, reset (async, active-low); ore_in/minute_in setting bus;
//   load_timp/load_alarma edge-triggered loads; semnal_stop_alarma stops ringing;
//   semnal_snooze used only with ALARMA_SNOOZE_EN; ore/minute/secunde time;
//   tick_sec one-cycle pulse per second; alarma ringing; alarma_armata armed.
// Optional: `define ALARMA_SNOOZE_EN adds a +5 min snooze trigger.
module ceas_alarma #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int RING_SEC = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] ore_in,
  input  logic [5:0] minute_in,
  input  logic       load_timp,
  input  logic       load_alarma,
  input  logic       semnal_stop_alarma,
  input  logic       semnal_snooze,
  output logic [4:0] ore,
  output logic [5:0] minute,
  output logic [5:0] secunde,
  output logic       tick_sec,
  output logic       alarma,
  output logic       alarma_armata
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);
  typedef enum logic [1:0] {DEZARMAT, ARMAT, SUNA} state_t;
  state_t st, st_nxt;
  logic [PW-1:0] presc;
  logic ld_t_q, ld_a_q;
  logic [4:0] al_h, nxt_h;
  logic [5:0] al_m, nxt_m, nxt_s;
  logic [7:0] ring_cnt;
  logic in_ok, ev_t, ev_a, tick, s_wrap, m_wrap, roll, trig, snz_ev, snz_hit;
  assign in_ok = ore_in <= 5'd23 && minute_in <= 6'd59;
  assign ev_t = load_timp & ~ld_t_q & in_ok;
  assign ev_a = load_alarma & ~ld_a_q & in_ok;
  // a time load restarts the second, so it suppresses a coincident tick
  assign tick = presc == TERM && !ev_t;
  assign s_wrap = secunde == 6'd59;
  assign m_wrap = minute == 6'd59;
  assign nxt_s = s_wrap ? '0 : secunde + 6'd1;
  assign nxt_m = !s_wrap ? minute : m_wrap ? '0 : minute + 6'd1;
  assign nxt_h = !(s_wrap && m_wrap) ? ore : ore == 5'd23 ? '0 : ore + 5'd1;
  // only a natural minute rollover can start ringing, never a time load
  assign roll = tick & s_wrap;
  assign trig = roll && ((nxt_h == al_h && nxt_m == al_m) || snz_hit);
  assign alarma = st == SUNA;
  assign alarma_armata = st != DEZARMAT;
  always_comb begin
    st_nxt = st;
    if (ev_a)
      st_nxt = ARMAT;
    else if (st == ARMAT && trig)
      st_nxt = SUNA;
    else if (st == SUNA && (semnal_stop_alarma || snz_ev || (tick && ring_cnt == 8'(RING_SEC - 1))))
      st_nxt = ARMAT;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      tick_sec <= 1'b0;
      ore <= '0;
      minute <= '0;
      secunde <= '0;
    end else if (ev_t) begin
      presc <= '0;
      tick_sec <= 1'b0;
      ore <= ore_in;
      minute <= minute_in;
      secunde <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      tick_sec <= tick;
      if (tick) begin
        ore <= nxt_h;
        minute <= nxt_m;
        secunde <= nxt_s;
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= DEZARMAT;
      ld_t_q <= 1'b0;
      ld_a_q <= 1'b0;
      al_h <= '0;
      al_m <= '0;
      ring_cnt <= '0;
    end else begin
      st <= st_nxt;
      ld_t_q <= load_timp;
      ld_a_q <= load_alarma;
      al_h <= ev_a ? ore_in : al_h;
      al_m <= ev_a ? minute_in : al_m;
      ring_cnt <= st != SUNA ? '0 : ring_cnt + 8'(tick);
    end
  end
`ifdef ALARMA_SNOOZE_EN
  logic snz_q, snz_v;
  logic [4:0] sz_h;
  logic [5:0] sz_m;
  logic [6:0] m_p5;
  assign m_p5 = {1'b0, minute} + 7'd5;
  assign snz_ev = semnal_snooze & ~snz_q & (st == SUNA) & ~ev_a;
  assign snz_hit = snz_v && nxt_h == sz_h && nxt_m == sz_m;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snz_q <= 1'b0;
      snz_v <= 1'b0;
      sz_h <= '0;
      sz_m <= '0;
    end else begin
      snz_q <= semnal_snooze;
      if (ev_a)
        snz_v <= 1'b0;
      else if (snz_ev) begin
        snz_v <= 1'b1;
        sz_m <= m_p5 >= 7'd60 ? 6'(m_p5 - 7'd60) : m_p5[5:0];
        sz_h <= m_p5 < 7'd60 ? ore : ore == 5'd23 ? '0 : ore + 5'd1;
      end else if (st == ARMAT && roll && snz_hit)
        snz_v <= 1'b0;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = semnal_snooze;
  assign snz_ev = 1'b0;
  assign snz_hit = 1'b0;
`endif
endmodule

// File: doc/ceas_alarma.md
Name: ceas_alarma

Overview:
- Timekeeping and alarm end of the time-setting interface.
- Consumes the setting bus (ore/minute plus the load_timp and load_alarma strobes) produced by the setting block.
- Keeps a running 24 h clock (hh:mm:ss), stores one alarm time and drives the alarm output.
- Sits between the setting block and the display/buzzer logic.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per second; must be >= 2.
- RING_SEC, 60, seconds the alarm rings if not stopped; range 1..255.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ore_in  in  5  hours from the setting block, valid range 0..23.
- minute_in  in  6  minutes from the setting block, valid range 0..59.
- load_timp  in  1  level; its rising edge loads the current time.
- load_alarma  in  1  level; its rising edge loads and arms the alarm.
- semnal_stop_alarma  in  1  level; while high, stops ringing.
- semnal_snooze  in  1  snooze request; used only with ALARMA_SNOOZE_EN, otherwise ignored.
- ore  out  5  current hours.
- minute  out  6  current minutes.
- secunde  out  6  current seconds.
- tick_sec  out  1  one-cycle pulse each second boundary.
- alarma  out  1  high while ringing.
- alarma_armata  out  1  high while an alarm is stored and armed.

Behaviour:
- Reset (reset=0, async): all of the following clear to 0 — ore, minute, secunde, prescaler, tick_sec, alarma, alarma_armata, stored alarm hh:mm, edge-detect registers, ring counter. FSM goes to DEZARMAT.
- Edge detect:
  - Registered copies of load_timp and load_alarma; a load event is input=1 while the registered copy=0.
  - A level held high never re-triggers.
  - Loads fire on edges only, because the setting block holds its load strobes high until its own reset.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1.
  - At terminal count it wraps to 0 and tick_sec=1 for exactly that next cycle.
- Counting on a tick:
  - secunde 59->0 carries to minute.
  - minute 59->0 carries to ore.
  - ore 23->0 wraps.
- load_timp event at cycle N:
  - At N+1: ore=ore_in, minute=minute_in, secunde=0, prescaler=0, no tick.
  - Load wins over a tick in the same cycle.
  - If ore_in>23 or minute_in>59, the event is ignored entirely.
- load_alarma event:
  - Stores the alarm hh:mm and sets alarma_armata=1 at N+1.
  - Out-of-range values are ignored.
- Both events in the same cycle: both are applied.
- FSM states: DEZARMAT, ARMAT, SUNA.
  - DEZARMAT -> ARMAT on a valid load_alarma.
  - ARMAT -> SUNA when a tick rolls secunde 59->0 and the new hh:mm equals the stored alarm. alarma=1 on the cycle after that tick.
  - A time equality produced by load_timp does NOT trigger ringing.
  - SUNA -> ARMAT when semnal_stop_alarma=1 (alarma=0 next cycle), or when the ring counter reaches RING_SEC ticks. The alarm stays armed for the next day.
  - SUNA + valid load_alarma: ringing stops, the new alarm is stored, state goes to ARMAT.
  - semnal_stop_alarma has no effect outside SUNA.
- alarma_armata = 1 in ARMAT and SUNA; 0 in DEZARMAT.
- Reset asserted mid-ring: alarma clears immediately (async), and the alarm is disarmed.

Optional Feature:
- Macro: ALARMA_SNOOZE_EN.
- Defined:
  - A rising edge on semnal_snooze while in SUNA stops ringing.
  - A separate snooze time is set to the current time + 5 min, wrapping modulo 24 h. The stored alarm is unchanged.
  - State goes to ARMAT; the next trigger fires on either the alarm time or the snooze time.
  - The snooze time is cleared when it fires, on any load_alarma, and on reset.
- Not defined:
  - semnal_snooze is unused.
  - No snooze registers exist.
  - Behaviour is exactly as above.

Test Plan (TICKS_PER_SEC=4, RING_SEC=3):
- Release reset, run 4 cycles -> tick_sec pulses once; secunde=1; ore=minute=0; alarma=alarma_armata=0.
- ore_in=23, minute_in=59, pulse load_timp, then run 60 s -> display reaches 23:59:59, then 00:00:00 on the next tick.
- Hold load_timp high for 100 cycles after a load -> time keeps counting with no reload; ore_in=24 with a fresh edge -> no change.
- Load alarm 00:01 with time 00:00:58 -> alarma=1 one cycle after the tick to 00:01:00; stays 1 for 3 ticks, then 0; alarma_armata stays 1.
- While ringing, assert semnal_stop_alarma -> alarma=0 next cycle; load_timp to 00:01 -> no re-ring.
- Reset low mid-ring -> alarma and alarma_armata are 0 immediately, without waiting for a clock edge; with ALARMA_SNOOZE_EN, snooze at 00:01:01 -> rings again at 00:06:00.
